// File: rtl/stack_sequencer.sv
// stack_sequencer: walks the push mask (ascending bit order) and then the pop
// mask (descending bit order). It issues one word-wide stack bus transaction
// per set bit, tracks SP, and returns popped words to the register file.
// Every output is a registered flop except bus_wdata. The registered bus
// outputs are computed from the next-cycle state, so the first request
// appears in the cycle right after start.
module stack_sequencer #(
  parameter int unsigned STEP = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] push_mask,
  input  logic [15:0] pop_mask,
  input  logic [15:0] sp_in,
  output logic [3:0]  reg_sel,
  input  logic [15:0] reg_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [15:0] bus_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_sel,
  output logic [15:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] sp_out
);

  typedef enum logic [1:0] {S_IDLE, S_PUSH, S_POP, S_FINISH} state_e;

  localparam logic [3:0]  SP_BIT   = 4'd4;   // push of SP uses the pre-sequence value
  localparam logic [3:0]  DISC_BIT = 4'd5;   // SP_DISCARD: no push, pop without writeback
  localparam logic [15:0] STEP_W   = STEP[15:0];

  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    lowest_bit = '0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) lowest_bit = i[3:0];
  endfunction

  function automatic logic [3:0] highest_bit(input logic [15:0] m);
    highest_bit = '0;
    for (int i = 0; i < 16; i++)
      if (m[i]) highest_bit = i[3:0];
  endfunction

  state_e      state_q, state_d;
  logic [15:0] pm_q, pm_d;        // pending pushes
  logic [15:0] qm_q, qm_d;        // pending pops
  logic [15:0] sp_q, sp_d;        // running SP
  logic [15:0] sp0_q, sp0_d;      // SP captured at start, pushed for bit 4
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [3:0]  reg_sel_q, reg_sel_d;
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] sp_out_q, sp_out_d;

  logic [3:0]  push_k, pop_k, nxt_push_k, nxt_pop_k;
  logic        acked;

  // Next-state, mask/SP bookkeeping and look-ahead of the registered bus outputs
  always_comb begin
    state_d    = state_q;
    pm_d       = pm_q;
    qm_d       = qm_q;
    sp_d       = sp_q;
    sp0_d      = sp0_q;
    wb_valid_d = 1'b0;
    wb_sel_d   = wb_sel_q;
    wb_data_d  = wb_data_q;
    done_d     = 1'b0;
    sp_out_d   = sp_out_q;
    push_k     = lowest_bit(pm_q);
    pop_k      = highest_bit(qm_q);
    acked      = bus_req_q & bus_ack;   // a stray ack with no request is ignored

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pm_d  = push_mask;
          qm_d  = pop_mask;
          sp_d  = sp_in;
          sp0_d = sp_in;
          if (push_mask != '0)     state_d = S_PUSH;
          else if (pop_mask != '0) state_d = S_POP;
          else                     state_d = S_FINISH;
        end
      end
      S_PUSH: begin
        if (pm_q != '0) begin
          if (push_k == DISC_BIT) begin
            pm_d[push_k] = 1'b0;           // one idle cycle, SP untouched
          end else if (acked) begin
            pm_d[push_k] = 1'b0;
            sp_d         = sp_q - STEP_W;
          end
        end
        if (pm_d == '0) state_d = (qm_q != '0) ? S_POP : S_FINISH;
      end
      S_POP: begin
        if (qm_q != '0 && acked) begin
          qm_d[pop_k] = 1'b0;
          sp_d        = sp_q + STEP_W;
          if (pop_k != DISC_BIT) begin
            wb_valid_d = 1'b1;
            wb_sel_d   = pop_k;
            wb_data_d  = bus_rdata;
          end
        end
        if (qm_d == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d   = 1'b1;
        sp_out_d = sp_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs for the next cycle, derived from the next-cycle masks and SP
    nxt_push_k = lowest_bit(pm_d);
    nxt_pop_k  = highest_bit(qm_d);
    bus_req_d  = 1'b0;
    bus_we_d   = 1'b0;
    bus_addr_d = '0;
    reg_sel_d  = '0;
    if (state_d == S_PUSH && pm_d != '0 && nxt_push_k != DISC_BIT) begin
      bus_req_d  = 1'b1;
      bus_we_d   = 1'b1;
      bus_addr_d = sp_d - STEP_W;
      reg_sel_d  = nxt_push_k;
    end else if (state_d == S_POP && qm_d != '0) begin
      bus_req_d  = 1'b1;
      bus_addr_d = sp_d;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any in-flight request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pm_q       <= '0;
      qm_q       <= '0;
      sp_q       <= '0;
      sp0_q      <= '0;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_addr_q <= '0;
      reg_sel_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sp_out_q   <= '0;
    end else begin
      state_q    <= state_d;
      pm_q       <= pm_d;
      qm_q       <= qm_d;
      sp_q       <= sp_d;
      sp0_q      <= sp0_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      reg_sel_q  <= reg_sel_d;
      wb_valid_q <= wb_valid_d;
      wb_sel_q   <= wb_sel_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sp_out_q   <= sp_out_d;
    end
  end

  assign reg_sel  = reg_sel_q;
  assign bus_req  = bus_req_q;
  assign bus_we   = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign wb_valid = wb_valid_q;
  assign wb_sel   = wb_sel_q;
  assign wb_data  = wb_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sp_out   = sp_out_q;

  // Write data follows the register file live; a push of SP sends the value from start
  assign bus_wdata = (bus_req_q && bus_we_q) ? ((reg_sel_q == SP_BIT) ? sp0_q : reg_data)
                                             : '0;

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: directed and randomized sequences are checked
// against a transaction-list model built straight from the mask/SP rules.
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] push_mask = '0, pop_mask = '0, sp_in = '0;
  logic [3:0]  reg_sel;
  logic [15:0] reg_data;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [15:0] bus_rdata = '0;
  logic        wb_valid;
  logic [3:0]  wb_sel;
  logic [15:0] wb_data;
  logic        busy, done;
  logic [15:0] sp_out;

  logic [15:0] rf [16];

  always #5 clk = ~clk;
  assign reg_data = rf[reg_sel];

  stack_sequencer #(.STEP(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .push_mask(push_mask), .pop_mask(pop_mask), .sp_in(sp_in),
    .reg_sel(reg_sel), .reg_data(reg_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data),
    .busy(busy), .done(done), .sp_out(sp_out)
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {logic we; logic [15:0] addr; logic [15:0] data; logic stable;} tx_t;
  typedef struct {logic [3:0] sel; logic [15:0] data;} wb_t;

  tx_t         obs_tx[$];
  wb_t         obs_wb[$];
  logic [15:0] rd_pre[$];
  logic [15:0] rd_log[$];
  int          done_cyc;
  logic [15:0] spo;
  logic        busy_ok, timed_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
  endtask

  // Drive one sequence cycle by cycle, acting as the bus slave, and log what the DUT does
  task automatic run_seq(input logic [15:0] pm, input logic [15:0] qm, input logic [15:0] sp,
                         input int dly, input bit spur, input bit extra);
    int          cnt;
    tx_t         cur;
    logic [15:0] rd;
    obs_tx.delete(); obs_wb.delete(); rd_log.delete();
    done_cyc = -1; busy_ok = 1'b1; timed_out = 1'b0; cnt = 0; spo = '0;
    cur = '{1'b0, 16'h0, 16'h0, 1'b1};
    @(negedge clk);
    push_mask = pm; pop_mask = qm; sp_in = sp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_mask = 16'($urandom); pop_mask = 16'($urandom); sp_in = 16'($urandom);
    for (int c = 1; c <= 400; c++) begin
      if (wb_valid) obs_wb.push_back('{wb_sel, wb_data});
      if (done) begin
        done_cyc = c; spo = sp_out;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      start = 1'b0;
      if (extra && c == 2) begin
        start = 1'b1; push_mask = ~pm; pop_mask = ~qm; sp_in = ~sp;
      end
      bus_ack = 1'b0;
      if (bus_req) begin
        if (cnt == 0) cur = '{bus_we, bus_addr, bus_wdata, 1'b1};
        else if ({bus_we, bus_addr, bus_wdata} !== {cur.we, cur.addr, cur.data}) cur.stable = 1'b0;
        if (cnt == dly) begin
          if (rd_pre.size() > 0) rd = rd_pre.pop_front();
          else rd = 16'($urandom);
          bus_rdata = rd; bus_ack = 1'b1;
          if (!cur.we) rd_log.push_back(rd);
          obs_tx.push_back(cur);
          cnt = 0;
        end else cnt++;
      end else if (spur) begin
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = 16'($urandom);
      end
      @(negedge clk);
    end
    if (done_cyc < 0) timed_out = 1'b1;
    bus_ack = 1'b0; start = 1'b0;
  endtask

  // Model: expected transfers straight from the mask/SP rules, compared with the log
  task automatic check_seq(input string tag, input logic [15:0] pm, input logic [15:0] qm,
                           input logic [15:0] sp, input int dly);
    logic        ewe[$];
    logic [15:0] eaddr[$], edata[$];
    wb_t         ewb[$];
    logic [15:0] s;
    int          nrd, ntx, n;
    s = sp; nrd = 0;
    for (int k = 0; k < 16; k++) begin
      if (pm[k] && k != 5) begin
        s = s - 16'd2;
        ewe.push_back(1'b1); eaddr.push_back(s);
        edata.push_back((k == 4) ? sp : rf[k]);
      end
    end
    for (int k = 15; k >= 0; k--) begin
      if (qm[k]) begin
        ewe.push_back(1'b0); eaddr.push_back(s); edata.push_back(16'h0);
        if (k != 5 && nrd < rd_log.size()) ewb.push_back('{4'(k), rd_log[nrd]});
        nrd++;
        s = s + 16'd2;
      end
    end
    ntx = ewe.size();
    chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
    chk({tag, "_ntx"}, 32'(obs_tx.size()), 32'(ntx));
    n = (obs_tx.size() < ntx) ? obs_tx.size() : ntx;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_we"}, 32'(obs_tx[i].we), 32'(ewe[i]));
      chk({tag, "_addr"}, 32'(obs_tx[i].addr), 32'(eaddr[i]));
      if (ewe[i]) chk({tag, "_wdata"}, 32'(obs_tx[i].data), 32'(edata[i]));
      chk({tag, "_stable"}, 32'(obs_tx[i].stable), 32'd1);
    end
    chk({tag, "_nwb"}, 32'(obs_wb.size()), 32'(ewb.size()));
    n = (obs_wb.size() < ewb.size()) ? obs_wb.size() : ewb.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_wbsel"}, 32'(obs_wb[i].sel), 32'(ewb[i].sel));
      chk({tag, "_wbdata"}, 32'(obs_wb[i].data), 32'(ewb[i].data));
    end
    chk({tag, "_spout"}, 32'(spo), 32'(s));
    chk({tag, "_donecyc"}, 32'(done_cyc), 32'(2 + $countones(pm) + $countones(qm) + dly * ntx));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    logic [15:0] pm, qm, sp;
    int          dly;
    randomize_rf();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctl", 32'({bus_req, bus_we, reg_sel, wb_valid, wb_sel, busy, done}), 32'd0);
    chk("rst_addr", 32'(bus_addr), 32'd0);
    chk("rst_wdata", 32'(bus_wdata), 32'd0);
    chk("rst_wbdata", 32'(wb_data), 32'd0);
    chk("rst_spout", 32'(sp_out), 32'd0);
    reset_n = 1'b1;

    // Push AW|CW|PC
    rf[0] = 16'h1111; rf[1] = 16'h2222; rf[14] = 16'h3333;
    run_seq(16'h4003, 16'h0000, 16'h0100, 0, 1'b0, 1'b0);
    check_seq("push3", 16'h4003, 16'h0000, 16'h0100, 0);
    chk("push3_done5", 32'(done_cyc), 32'd5);
    chk("push3_sp", 32'(spo), 32'h00FA);

    // Pop PC|PS|PSW with fixed read data
    rd_pre.delete(); rd_pre.push_back(16'hA); rd_pre.push_back(16'hB); rd_pre.push_back(16'hC);
    run_seq(16'h0000, 16'h4C00, 16'h00FA, 0, 1'b0, 1'b0);
    check_seq("pop3", 16'h0000, 16'h4C00, 16'h00FA, 0);
    chk("pop3_sp", 32'(spo), 32'h0100);
    if (obs_wb.size() > 0) chk("pop3_first_sel", 32'(obs_wb[0].sel), 32'd14);

    // POP R style mask, SP_DISCARD read without writeback
    run_seq(16'h0000, 16'h01EF, 16'h0200, 0, 1'b1, 1'b0);
    check_seq("popr", 16'h0000, 16'h01EF, 16'h0200, 0);
    chk("popr_sp", 32'(spo), 32'h0210);
    chk("popr_nwb", 32'(obs_wb.size()), 32'd7);

    // Push SP with a slow ack
    run_seq(16'h0010, 16'h0000, 16'h1234, 3, 1'b0, 1'b0);
    check_seq("pushsp", 16'h0010, 16'h0000, 16'h1234, 3);
    if (obs_tx.size() > 0) chk("pushsp_wdata", 32'(obs_tx[0].data), 32'h1234);

    // SP wrap both ways, empty masks
    run_seq(16'h0001, 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
    check_seq("wrap_dn", 16'h0001, 16'h0000, 16'h0000, 0);
    chk("wrap_dn_sp", 32'(spo), 32'hFFFE);
    run_seq(16'h0000, 16'h0001, 16'hFFFE, 1, 1'b1, 1'b0);
    check_seq("wrap_up", 16'h0000, 16'h0001, 16'hFFFE, 1);
    run_seq(16'h0000, 16'h0000, 16'h5678, 0, 1'b1, 1'b0);
    check_seq("empty", 16'h0000, 16'h0000, 16'h5678, 0);
    chk("empty_done2", 32'(done_cyc), 32'd2);

    // Push with SP_DISCARD plus pops, start pulse while busy must be ignored
    run_seq(16'h0023, 16'h0021, 16'h0800, 0, 1'b1, 1'b1);
    check_seq("mixed", 16'h0023, 16'h0021, 16'h0800, 0);

    // Reset with a request pending
    @(negedge clk);
    push_mask = 16'h0003; pop_mask = '0; sp_in = 16'h0400; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pend_req", 32'(bus_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(bus_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'({bus_req, busy, done}), 32'd0);

    // Randomized sequences
    for (int it = 0; it < 24; it++) begin
      randomize_rf();
      pm  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      qm  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      sp  = 16'($urandom);
      dly = $urandom_range(0, 2);
      run_seq(pm, qm, sp, dly, 1'($urandom_range(0, 1)),
              (pm != '0 || qm != '0) && ($urandom_range(0, 1) == 1));
      check_seq("rand", pm, qm, sp, dly);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Sequences multi-register stack transfers for the V30-class core: PUSH R/POP R, interrupt entry/RETI, far CALL/RET and PREPARE/DISPOSE frame saves.
- Takes the 16-bit push and pop masks produced by pre-decode, which use the STACK_* bit layout (bit0 AW … bit14 PC, bit15 OPERAND).
- Issues one word-wide stack bus transaction per set bit, computes SS-relative addresses from SP, and returns popped words to the register file.
- Sits between the execute unit and the bus interface unit.

Parameters:
- STEP, 2, byte decrement/increment applied to SP per word transferred.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled only in IDLE
push_mask  in  16  STACK_* bits to push; latched on start
pop_mask  in  16  STACK_* bits to pop; latched on start
sp_in  in  16  SP value at start; latched
reg_sel  out  4  bit index currently being pushed; selects the register-file read port
reg_data  in  16  register-file value for reg_sel (combinational from datapath)
bus_req  out  1  stack transaction request
bus_we  out  1  1 = write (push), 0 = read (pop)
bus_addr  out  16  SS offset
bus_wdata  out  16  push data
bus_ack  in  1  transaction complete this cycle
bus_rdata  in  16  pop data; valid with bus_ack
wb_valid  out  1  one-cycle pulse: write wb_data to register wb_sel
wb_sel  out  4  STACK_* bit index of popped word
wb_data  out  16  popped word
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
sp_out  out  16  final SP; valid with done and held until the next start

Behaviour:
- Reset (async, asserted): state=IDLE. All outputs 0: bus_req, bus_we, bus_addr, bus_wdata, reg_sel, wb_*, busy, done, sp_out. Internal masks and SP are cleared. Any in-flight request is abandoned immediately.
- States: IDLE, PUSH, POP, FINISH. All outputs are registered except bus_wdata.
- IDLE: start=1 → latch push_mask to pm, pop_mask to qm, sp_in to sp. Go to PUSH. busy=1 from the next cycle.
- PUSH:
  - If pm has no bits set, go to POP.
  - Otherwise k = lowest set bit of pm. Drive bus_req=1, bus_we=1, bus_addr=sp−STEP (mod 2^16), reg_sel=k.
  - bus_wdata = reg_data, except k=4 (SP), which drives the latched sp_in, i.e. the pre-sequence SP.
  - On bus_ack: clear bit k, sp ← sp−STEP. The next pending item is presented in the following cycle with no idle gap.
  - Bit 5 (SP_DISCARD) in pm is cleared in a single cycle with no bus transaction and no SP change.
- POP:
  - If qm has no bits set, go to FINISH.
  - Otherwise k = highest set bit of qm. Drive bus_req=1, bus_we=0, bus_addr=sp.
  - On bus_ack: wb_valid=1 next cycle with wb_sel=k, wb_data=bus_rdata. Clear bit k, sp ← sp+STEP (mod 2^16).
  - Bit 5 performs the read and advances SP but suppresses wb_valid.
- Ordering:
  - Push is ascending bit order (AW,CW,…,IY; PSW,PS,PC). Pop is descending (IY…AW; PC,PS,PSW).
  - When both masks are nonzero, all pushes complete before any pop.
- FINISH: done=1, sp_out=sp, busy=0 the same cycle. Return to IDLE. Another start is accepted the following cycle.
- bus_req stays high with addr/we/wdata stable until bus_ack. bus_ack while bus_req=0 is ignored.
- start while not IDLE is ignored. Both masks zero → done pulses 2 cycles after start, sp_out=sp_in.
- Latency with bus_ack tied high: first bus_req at start+1. N transfers → done at start+N+2.
- SP wrap: 0x0000−2 = 0xFFFE; 0xFFFE+2 = 0x0000, no error flagged.

Test Plan:
- Push AW|CW|PC (0x4003), sp_in=0x0100, ack tied high, reg_data=0x1111/0x2222/0x3333 for sel 0/1/14 → writes 0x1111@0x00FE, 0x2222@0x00FC, 0x3333@0x00FA in that order; done at start+5, sp_out=0x00FA.
- Pop PC|PS|PSW (0x4C00), sp_in=0x00FA, rdata 0xA,0xB,0xC → reads 0x00FA,0x00FC,0x00FE; wb_sel 14,11,10 with data 0xA,0xB,0xC; sp_out=0x0100.
- Pop mask 0x01FF minus bit4 plus bit5 (POP R), sp_in=0x0200 → 8 reads; no wb_valid for sel 5; sp_out=0x0210.
- Push SP (0x0010), sp_in=0x1234, ack delayed 3 cycles → bus_wdata=0x1234 held stable for 4 cycles @0x1232; done at ack+2.
- sp_in=0x0000, push AW → addr 0xFFFE, sp_out=0xFFFE. Both masks zero → done at start+2, no bus_req.
- Assert reset_n=0 while bus_req pending → bus_req, busy drop immediately. After release, idle until the next start, and a start pulse during busy is ignored.
